// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-running divider with selectable tap, debounced buttons,
// run/halt/single-step FSM. Optional CE_COUNT_EN adds a 16-bit ce_count output.

module cpu_clk_ctrl_btn #(
    parameter int DEB_CYCLES     = 270000,
    parameter int SYNC_STAGES    = 2,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic                   pin_act;
    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [CW-1:0]          cnt;
    logic                   level_d;

    assign pin_act = BTN_ACTIVE_LOW ? ~pin : pin;
    assign synced  = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], pin_act};
            level_d <= level;
            press   <= level & ~level_d;
            // Level is accepted on the edge where the count would reach DEB_CYCLES.
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module cpu_clk_ctrl #(
    parameter int N_BTN          = 2,
    parameter int DIV_WIDTH      = 24,
    parameter int DEB_CYCLES     = 270000,
    parameter int SYNC_STAGES    = 2,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int MODE_BTN       = 0,
    parameter int STEP_BTN       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BTN-1:0]     btn_raw,
    input  logic [4:0]           rate_sel,
    output logic [DIV_WIDTH-1:0] counter,
    output logic                 cpu_ce,
    output logic                 running,
    output logic [N_BTN-1:0]     btn_level,
    output logic [N_BTN-1:0]     btn_press
`ifdef CE_COUNT_EN
    ,
    output logic [15:0]          ce_count
`endif
);
    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

    state_t               state, state_next;
    int                   tap;
    logic [DIV_WIDTH-1:0] mask;
    logic                 tick;

    always_ff @(posedge clk) begin
        if (!rst) counter <= '0;
        else      counter <= counter + DIV_WIDTH'(1);
    end

    // Out-of-range selects clamp to the fastest tap.
    always_comb begin
        tap = 0;
        if (int'(rate_sel) <= DIV_WIDTH - 1) tap = DIV_WIDTH - 1 - int'(rate_sel);
        for (int i = 0; i < DIV_WIDTH; i++) mask[i] = (i <= tap);
    end

    assign tick = &(counter | ~mask);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        cpu_clk_ctrl_btn #(
            .DEB_CYCLES    (DEB_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .pin  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cpu_ce     = 1'b0;
        running    = 1'b0;
        case (state)
            RUN: begin
                running = 1'b1;
                cpu_ce  = tick;
                if (btn_press[MODE_BTN]) state_next = HALT;
            end
            HALT: begin
                // Mode wins over a simultaneous step.
                if (btn_press[MODE_BTN])      state_next = RUN;
                else if (btn_press[STEP_BTN]) state_next = STEP;
            end
            STEP: begin
                cpu_ce     = 1'b1;
                state_next = HALT;
            end
            default: state_next = RUN;
        endcase
    end

`ifdef CE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)        ce_count <= '0;
        else if (cpu_ce) ce_count <= ce_count + 16'd1;
    end
`endif
endmodule
